// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared types and defaults for the memory bus arbiter
//
// Purpose: arbiter FSM state type, default parameter values, requester
// index assignments and a small wrap-around increment helper.
// Ports: none (package).
package mem_bus_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int NREQ_DEF      = 3;
   localparam int MAX_BURST_DEF = 8;
   localparam int AW_DEF        = 16;
   localparam int DW_DEF        = 16;

   localparam int REQ_TITLE = 0;
   localparam int REQ_GAME  = 1;
   localparam int REQ_DMA   = 2;

   // (idx + 1) mod n, written out so non-power-of-2 n wraps correctly
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - requester/bus bundle between requesters and the arbiter
//
// Purpose: groups the per-requester command fields and the shared RAM bus.
// Signals:
//   REQ/REQ_WRITE      per-requester request and write flag
//   REQ_ADDR/REQ_DATAW flattened per-requester address / write data (slice i at [i*W +: W])
//   GNT/RVALID         one-hot grant and one-hot read-return flag
//   memEnable/memWrite/memAddr/memDataW  shared bus access
// Modports: master = arbiter side, slave = requester/memory side.
interface mem_bus_if
   import mem_bus_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int AW   = AW_DEF,
   parameter int DW   = DW_DEF
);

   logic [NREQ-1:0]    REQ;
   logic [NREQ-1:0]    REQ_WRITE;
   logic [NREQ*AW-1:0] REQ_ADDR;
   logic [NREQ*DW-1:0] REQ_DATAW;
   logic [NREQ-1:0]    GNT;
   logic [NREQ-1:0]    RVALID;
   logic               memEnable;
   logic               memWrite;
   logic [AW-1:0]      memAddr;
   logic [DW-1:0]      memDataW;

   modport master (
      input  REQ, REQ_WRITE, REQ_ADDR, REQ_DATAW,
      output GNT, RVALID, memEnable, memWrite, memAddr, memDataW
   );

   modport slave (
      output REQ, REQ_WRITE, REQ_ADDR, REQ_DATAW,
      input  GNT, RVALID, memEnable, memWrite, memAddr, memDataW
   );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority picker
//
// Purpose: selects the first set request bit scanning upward from ptr_i,
// wrapping past N-1 back to 0.
// Ports:
//   req_i     request vector
//   ptr_i     scan start index (always < N)
//   onehot_o  one-hot winner
//   idx_o     winner index
//   valid_o   any request present
module rr_pick #(
   parameter int N  = 3,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  onehot_o,
   output logic [PW-1:0] idx_o,
   output logic          valid_o
);

   logic found;

   always_comb begin
      onehot_o = '0;
      idx_o    = '0;
      found    = 1'b0;
      for (int i = 0; i < N; i++) begin
         int j;
         j = int'(ptr_i) + i;
         if (j >= N) j = j - N;
         if (!found && req_i[j]) begin
            found       = 1'b1;
            idx_o       = PW'(j);
            onehot_o[j] = 1'b1;
         end
      end
      valid_o = found;
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin, burst-limited arbiter for the shared RAM/VRAM bus
//
// Purpose: grants the memory bus to one of NREQ requesters at a time, issues
// one access per cycle for the owner, forces re-arbitration after MAX_BURST
// accesses and flags one-cycle-latency read returns per requester.
// Ports:
//   CLK      system clock
//   RESET_N  synchronous active-low reset
//   bus      mem_bus_if.master (requests in; GNT, RVALID and memory bus out)
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int NREQ      = NREQ_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF,
   parameter int AW        = AW_DEF,
   parameter int DW        = DW_DEF
) (
   input  logic      CLK,
   input  logic      RESET_N,
   mem_bus_if.master bus
);

   localparam int PW = $clog2(NREQ);
   localparam int CW = $clog2(MAX_BURST + 1);

   state_t          state_q;
   logic [NREQ-1:0] gnt_q;
   logic [NREQ-1:0] rvalid_q;
   logic [PW-1:0]   owner_q;
   logic [PW-1:0]   rr_ptr_q;
   logic [CW-1:0]   cnt_q;

   logic            owner_req;
   logic            access;
   logic            rd_access;
   logic            last_beat;
   logic            end_tenure;
   logic [PW-1:0]   next_ptr_d;
   logic [PW-1:0]   pick_ptr;
   logic [NREQ-1:0] pick_onehot;
   logic [PW-1:0]   pick_idx;
   logic            pick_valid;

   assign owner_req  = bus.REQ[owner_q];
   assign access     = (state_q == GRANT) && owner_req;
   assign rd_access  = access && !bus.REQ_WRITE[owner_q];
   assign last_beat  = (cnt_q == CW'(MAX_BURST - 1));
   // Tenure ends when the owner lets go or when this access is its last allowed one
   assign end_tenure = (state_q == GRANT) && (!owner_req || last_beat);
   assign next_ptr_d = PW'(wrap_inc(int'(owner_q), NREQ));

   // One picker serves both IDLE and handover; during GRANT it already scans
   // from the post-tenure pointer so the handover has no bubble.
   assign pick_ptr = (state_q == GRANT) ? next_ptr_d : rr_ptr_q;

   rr_pick #(
      .N  (NREQ),
      .PW (PW)
   ) u_pick (
      .req_i    (bus.REQ),
      .ptr_i    (pick_ptr),
      .onehot_o (pick_onehot),
      .idx_o    (pick_idx),
      .valid_o  (pick_valid)
   );

   assign bus.GNT       = gnt_q;
   assign bus.RVALID    = rvalid_q;
   assign bus.memEnable = access;
   assign bus.memWrite  = access && bus.REQ_WRITE[owner_q];
   assign bus.memAddr   = access ? bus.REQ_ADDR[int'(owner_q)*AW +: AW]  : '0;
   assign bus.memDataW  = access ? bus.REQ_DATAW[int'(owner_q)*DW +: DW] : '0;

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         rvalid_q <= '0;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         // gnt_q is the owner's one-hot, so it tags the read with the owner at issue time
         rvalid_q <= rd_access ? gnt_q : '0;
         case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  state_q <= GRANT;
                  gnt_q   <= pick_onehot;
                  owner_q <= pick_idx;
                  cnt_q   <= '0;
               end
            end
            GRANT: begin
               if (end_tenure) begin
                  rr_ptr_q <= next_ptr_d;
                  if (pick_valid) begin
                     gnt_q   <= pick_onehot;
                     owner_q <= pick_idx;
                     cnt_q   <= '0;
                  end else begin
                     state_q <= IDLE;
                     gnt_q   <= '0;
                  end
               end else if (access) begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               gnt_q   <= '0;
            end
         endcase
      end
   end

endmodule
